// File: rtl/interleaver_pkg.sv
// Shared constants and FSM encoding for the interleaver frame scheduler.
package interleaver_pkg;
  localparam int FRAME_BITS = 64;
  localparam int TAG_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } state_t;
endpackage

// File: rtl/interleaver_frame_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   grant_id,
  output logic               found
);
  logic [SRC_W:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    // Scan farthest offset first so the requester nearest rr_ptr overrides.
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      idx = {1'b0, rr_ptr} + (SRC_W+1)'(off);
      if (idx >= (SRC_W+1)'(NUM_SRC)) idx = idx - (SRC_W+1)'(NUM_SRC);
      if (advance && req[idx[SRC_W-1:0]]) begin
        grant                  = '0;
        grant[idx[SRC_W-1:0]]  = 1'b1;
        grant_id               = idx[SRC_W-1:0];
        found                  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/interleaver_frame_scheduler.sv
// Round-robin frame scheduler in front of a shared 64-bit block interleaver,
// with zero-padding of stalled frames and source tagging of interleaved output.
module interleaver_frame_scheduler
  import interleaver_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk2,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] src_din,
  input  logic [NUM_SRC-1:0] src_valid,
  output logic [NUM_SRC-1:0] grant,
  output logic               frame_done,
  output logic               il_din,
  output logic               il_din_valid,
  input  logic               il_dout,
  input  logic               il_dout_valid,
  output logic               out_bit,
  output logic               out_valid,
  output logic [SRC_W-1:0]   out_src,
  output logic               out_sof,
  output logic               out_eof,
  output logic               pad_err,
  output logic               orphan_err
);
  localparam int         IDLE_W   = $clog2(TIMEOUT + 1);
  localparam int         PTR_W    = $clog2(TAG_DEPTH);
  localparam int         CNT_W    = $clog2(TAG_DEPTH + 1);
  localparam logic [6:0] LAST_BIT = 7'(FRAME_BITS - 1);

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]    gid_q, gid_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [6:0]          bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                pad_err_q;
  logic                set_pad, push, pop;

  logic [SRC_W-1:0]    tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    tag_cnt_q;
  logic                fifo_full, fifo_empty;

  logic [6:0]          out_cnt_q;
  logic                out_bit_q, out_valid_q, out_sof_q, out_eof_q, orphan_err_q;
  logic [SRC_W-1:0]    out_src_q;

  logic [NUM_SRC-1:0]  arb_grant;
  logic [SRC_W-1:0]    arb_id;
  logic                arb_found;

  assign fifo_full  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (tag_cnt_q == '0);

  rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_arb (
    .req      (req),
    .advance  ((state_q == IDLE) && !fifo_full),
    .rr_ptr   (rr_ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .found    (arb_found)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gid_d        = gid_q;
    rr_ptr_d     = rr_ptr_q;
    bit_cnt_d    = bit_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    il_din       = 1'b0;
    il_din_valid = 1'b0;
    frame_done   = 1'b0;
    push         = 1'b0;
    set_pad      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d    = arb_grant;
          gid_d      = arb_id;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        il_din       = src_din[gid_q];
        il_din_valid = src_valid[gid_q];
        if (il_din_valid) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d = PAD;
            set_pad = 1'b1;
          end
        end
      end
      PAD: begin
        il_din_valid = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // The 64th accepted bit closes the frame whether it came from the source or padding.
    if (il_din_valid) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q == LAST_BIT) begin
        frame_done = 1'b1;
        push       = 1'b1;
        grant_d    = '0;
        bit_cnt_d  = '0;
        rr_ptr_d   = (gid_q == SRC_W'(NUM_SRC - 1)) ? '0 : gid_q + 1'b1;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gid_q      <= '0;
      rr_ptr_q   <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      pad_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gid_q      <= gid_d;
      rr_ptr_q   <= rr_ptr_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      pad_err_q  <= pad_err_q | set_pad;
    end
  end

  assign pop = il_dout_valid && !fifo_empty && (out_cnt_q == LAST_BIT);

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_cnt_q    <= '0;
      out_cnt_q    <= '0;
      out_bit_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_src_q    <= '0;
      orphan_err_q <= 1'b0;
    end else begin
      if (push) begin
        tag_mem_q[wr_ptr_q] <= gid_q;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      tag_cnt_q   <= tag_cnt_q + CNT_W'(push) - CNT_W'(pop);
      out_bit_q   <= il_dout;
      out_valid_q <= il_dout_valid;
      out_sof_q   <= il_dout_valid && (out_cnt_q == '0);
      out_eof_q   <= il_dout_valid && (out_cnt_q == LAST_BIT);
      if (il_dout_valid) begin
        out_src_q <= fifo_empty ? '0 : tag_mem_q[rd_ptr_q];
        out_cnt_q <= (out_cnt_q == LAST_BIT) ? '0 : out_cnt_q + 1'b1;
        if (fifo_empty) orphan_err_q <= 1'b1;
      end
    end
  end

  assign grant      = grant_q;
  assign pad_err    = pad_err_q;
  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign out_src    = out_src_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign orphan_err = orphan_err_q;
endmodule

// File: tb/tb_interleaver_frame_scheduler.sv
// Self-checking bench: source models, an 8x8 transpose interleaver model and an output scoreboard.
module tb_interleaver_frame_scheduler;
  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;
  localparam int TIMEOUT = 16;

  logic         clk2 = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [3:0]   src_din = '0;
  logic [3:0]   src_valid = '0;
  logic [3:0]   grant;
  logic         frame_done, il_din, il_din_valid;
  logic         il_dout = 1'b0;
  logic         il_dout_valid = 1'b0;
  logic         out_bit, out_valid, out_sof, out_eof, pad_err, orphan_err;
  logic [1:0]   out_src;

  always #5 clk2 = ~clk2;

  interleaver_frame_scheduler #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk2(clk2), .rst_n(rst_n), .req(req), .src_din(src_din), .src_valid(src_valid),
    .grant(grant), .frame_done(frame_done), .il_din(il_din), .il_din_valid(il_din_valid),
    .il_dout(il_dout), .il_dout_valid(il_dout_valid), .out_bit(out_bit), .out_valid(out_valid),
    .out_src(out_src), .out_sof(out_sof), .out_eof(out_eof), .pad_err(pad_err),
    .orphan_err(orphan_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pat(input int s, input int k);
    return (((k * (s + 3)) >> 2) % 2) == 1;
  endfunction

  function automatic int perm(input int j);
    return (j % 8) * 8 + j / 8;
  endfunction

  // Source models: stream budget[s] bits while granted, random junk otherwise.
  int budget [NUM_SRC] = '{default: 64};
  int sent   [NUM_SRC] = '{default: 0};

  always @(posedge clk2) begin
    #1;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant[s] && sent[s] < budget[s]) begin
        src_valid[s] = 1'b1;
        src_din[s]   = pat(s, sent[s]);
        sent[s]++;
      end else if (grant[s]) begin
        src_valid[s] = 1'b0;
        src_din[s]   = 1'($urandom_range(0, 1));
      end else begin
        sent[s]      = 0;
        src_valid[s] = 1'($urandom_range(0, 1));
        src_din[s]   = 1'($urandom_range(0, 1));
      end
    end
  end

  typedef struct { int src; int budget; int gap; } frame_t;
  typedef struct { logic b; logic [1:0] src; logic sof; logic eof; logic tags; } obit_t;

  frame_t      exp_fr [$];
  obit_t       pend   [$];
  obit_t       sb     [$];
  frame_t      cur = '{0, 64, 0};
  logic [63:0] cap, exp_data;
  int          wcnt = 0, gap = 0, fd_bad = 0, gr_bad = 0, eof_seen = 0;
  logic        drain_en = 1'b1, inj = 1'b0;
  obit_t       o;

  // Interleaver model and output scoreboard, all evaluated on the falling edge.
  always @(negedge clk2) begin
    if (!rst_n) begin
      wcnt = 0; gap = 0; fd_bad = 0; gr_bad = 0;
      pend.delete(); sb.delete();
      il_dout = 1'b0; il_dout_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("out_valid_unexpected", 64'(out_valid), 64'd0);
        end else begin
          o = sb.pop_front();
          if (o.tags) check("out_bit_src_sof_eof", 64'({out_bit, out_src, out_sof, out_eof}),
                            64'({o.b, o.src, o.sof, o.eof}));
          else        check("orphan_bit_src", 64'({out_bit, out_src}), 64'({o.b, o.src}));
        end
        if (out_eof) eof_seen++;
      end
      il_dout = 1'b0; il_dout_valid = 1'b0;
      if (inj) begin
        il_dout = 1'b1; il_dout_valid = 1'b1;
        sb.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 1'b0});
      end else if (drain_en && pend.size() > 0) begin
        o = pend.pop_front();
        il_dout = o.b; il_dout_valid = 1'b1;
        sb.push_back(o);
      end
      if (grant != 0 && !il_din_valid) gap++;
      if (frame_done !== (il_din_valid && wcnt == 63)) fd_bad++;
      if (il_din_valid) begin
        if (wcnt == 0) begin
          if (exp_fr.size() == 0) begin
            check("frame_expected", 64'(exp_fr.size()), 64'd1);
            cur = '{0, 64, 0};
          end else begin
            cur = exp_fr.pop_front();
          end
        end
        if (grant !== 4'(1 << cur.src)) gr_bad++;
        cap[wcnt] = il_din;
        wcnt++;
        if (wcnt == 64) begin
          for (int k = 0; k < 64; k++) exp_data[k] = (k < cur.budget) ? pat(cur.src, k) : 1'b0;
          check("frame_data", cap, exp_data);
          check("frame_grant_errs", 64'(gr_bad), 64'd0);
          check("frame_done_errs", 64'(fd_bad), 64'd0);
          check("frame_idle_gap", 64'(gap), 64'(cur.gap));
          for (int j = 0; j < 64; j++)
            pend.push_back('{exp_data[perm(j)], 2'(cur.src), j == 0, j == 63, 1'b1});
          wcnt = 0; gap = 0; gr_bad = 0; fd_bad = 0;
        end
      end
    end
  end

  task automatic wait_done(input int max);
    int c = 0;
    do begin @(negedge clk2); c++; end while (frame_done !== 1'b1 && c < max);
    check("frame_done_seen", 64'(frame_done), 64'd1);
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((pend.size() != 0 || sb.size() != 0) && c < 400) begin @(negedge clk2); c++; end
    repeat (3) @(negedge clk2);
    check("drain_complete", 64'(pend.size() + sb.size()), 64'd0);
    @(posedge clk2); #1;
  endtask

  task automatic set_budget(input int b);
    for (int s = 0; s < NUM_SRC; s++) budget[s] = b;
  endtask

  typedef struct { logic [3:0] req; int budget; int src; int gap; logic pad; } vec_t;
  vec_t tbl [11];

  initial begin
    int c, g, eof0;
    tbl[0]  = '{4'b1111, 64, 0, 0,  1'b0};
    tbl[1]  = '{4'b1111, 64, 1, 0,  1'b0};
    tbl[2]  = '{4'b1111, 64, 2, 0,  1'b0};
    tbl[3]  = '{4'b1111, 64, 3, 0,  1'b0};
    tbl[4]  = '{4'b1111, 64, 0, 0,  1'b0};
    tbl[5]  = '{4'b0001, 64, 0, 0,  1'b0};
    tbl[6]  = '{4'b0010, 40, 1, 16, 1'b1};
    tbl[7]  = '{4'b0100, 64, 2, 0,  1'b1};
    tbl[8]  = '{4'b1001, 64, 3, 0,  1'b1};
    tbl[9]  = '{4'b1001, 10, 0, 16, 1'b1};
    tbl[10] = '{4'b0110, 64, 1, 0,  1'b1};

    repeat (3) @(posedge clk2);
    #1;
    check("reset_outputs", 64'({grant, frame_done, il_din, il_din_valid, out_bit, out_valid,
                                out_src, out_sof, out_eof, pad_err, orphan_err}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      set_budget(tbl[i].budget);
      exp_fr.push_back('{tbl[i].src, tbl[i].budget, tbl[i].gap});
      wait_done(300);
      @(posedge clk2); #1;
      check("grant_released", 64'(grant), 64'd0);
      check("tbl_pad_err", 64'(pad_err), 64'(tbl[i].pad));
    end
    req = 4'b0000;

    // Undrained output: two frames fill the tag FIFO, the third grant waits for an eof pop.
    wait_drain();
    drain_en = 1'b0;
    set_budget(64);
    req = 4'b0001; exp_fr.push_back('{0, 64, 0});
    wait_done(300); @(posedge clk2); #1;
    req = 4'b0010; exp_fr.push_back('{1, 64, 0});
    wait_done(300); @(posedge clk2); #1;
    req = 4'b0100; exp_fr.push_back('{2, 64, 0});
    g = 0;
    repeat (80) begin @(negedge clk2); if (grant != 0) g++; end
    check("full_fifo_blocks_grant", 64'(g), 64'd0);
    #1;
    eof0 = eof_seen;
    drain_en = 1'b1;
    c = 0;
    while (grant == 0 && c < 200) begin @(negedge clk2); c++; end
    check("grant_after_pop", 64'(grant), 64'b0100);
    check("eofs_before_grant", 64'(eof_seen - eof0), 64'd1);
    wait_done(300); @(posedge clk2); #1;
    req = 4'b0000;

    // Reset in the middle of a frame, then the pointer restarts at source 0.
    wait_drain();
    req = 4'b0010; exp_fr.push_back('{1, 64, 0});
    c = 0;
    while (wcnt != 30 && c < 200) begin @(negedge clk2); c++; end
    check("reached_bit30", 64'(wcnt), 64'd30);
    @(posedge clk2); #1;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", 64'({grant, frame_done, il_din, il_din_valid, out_bit, out_valid,
                                         out_src, out_sof, out_eof, pad_err, orphan_err}), 64'd0);
    exp_fr.delete();
    repeat (2) @(posedge clk2);
    #1;
    rst_n = 1'b1;
    req = 4'b1111; exp_fr.push_back('{0, 64, 0});
    @(posedge clk2); #1;
    check("first_grant_after_reset", 64'(grant), 64'b0001);
    wait_done(300); @(posedge clk2); #1;
    req = 4'b0000;
    check("pad_err_cleared", 64'(pad_err), 64'd0);

    // Interleaver output with no frame tagged.
    wait_drain();
    check("orphan_err_before", 64'(orphan_err), 64'd0);
    inj = 1'b1;
    @(posedge clk2); #1;
    inj = 1'b0;
    repeat (3) @(posedge clk2);
    #1;
    check("orphan_err_set", 64'(orphan_err), 64'd1);
    check("scoreboard_empty", 64'(sb.size() + pend.size() + exp_fr.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
